nonce_scheduler: RTL and testbench

//   Shares a pool of NUM_CORES SHA-256 bitcoin hash cores across one nonce sweep.

---
 rtl/nonce_scheduler.sv | 159 +++++++++++++++
 tb/tb_nonce_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// Nonce sweep scheduler: dispatches consecutive nonces to a pool of hash
// cores and writes each captured h0 to output_addr + nonce index.
module nonce_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             nonce_base,
    input  logic [CNT_W-1:0]        nonce_count,
    input  logic [15:0]             output_addr,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [32*NUM_CORES-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [32*NUM_CORES-1:0] core_h0,
    output logic                    mem_we,
    output logic [15:0]             mem_addr,
    output logic [31:0]             mem_write_data
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DONE     = 2'd2;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_PEND = 2'd2;

    logic [1:0]       state;
    logic [31:0]      base_r;
    logic [CNT_W-1:0] count_r;
    logic [15:0]      addr_r;
    logic [CNT_W-1:0] next_idx;
    logic [CNT_W-1:0] written;
    logic [PTR_W-1:0] rr_ptr;

    logic [1:0]       status [NUM_CORES];
    logic [CNT_W-1:0] idx_r  [NUM_CORES];
    logic [31:0]      h0_r   [NUM_CORES];

    logic             dsp_ok;
    logic             dsp_hit;
    logic [PTR_W-1:0] dsp_sel;
    logic             wr_ok;
    logic             wr_hit;
    logic [PTR_W-1:0] wr_sel;
    logic [PTR_W-1:0] wr_nxt;

    assign busy   = (state == S_DISPATCH);
    assign done   = (state == S_DONE);
    assign dsp_ok = busy && (next_idx < count_r) && dsp_hit;
    assign wr_ok  = busy && wr_hit;
    assign wr_nxt = (wr_sel == PTR_W'(NUM_CORES - 1)) ? '0 : wr_sel + 1'b1;

    // Descending scan so the lowest-numbered idle core wins.
    always_comb begin
        dsp_hit = 1'b0;
        dsp_sel = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (status[i] == C_IDLE) begin
                dsp_hit = 1'b1;
                dsp_sel = PTR_W'(i);
            end
        end
    end

    // Round-robin: first pending core at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        j      = 0;
        wr_hit = 1'b0;
        wr_sel = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            if (status[j] == C_PEND) begin
                wr_hit = 1'b1;
                wr_sel = PTR_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            base_r         <= '0;
            count_r        <= '0;
            addr_r         <= '0;
            next_idx       <= '0;
            written        <= '0;
            rr_ptr         <= '0;
            core_start     <= '0;
            core_nonce     <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                status[i] <= C_IDLE;
                idx_r[i]  <= '0;
                h0_r[i]   <= '0;
            end
        end else begin
            core_start <= '0;
            mem_we     <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_r   <= nonce_base;
                        count_r  <= nonce_count;
                        addr_r   <= output_addr;
                        next_idx <= '0;
                        written  <= '0;
                        rr_ptr   <= '0;
                        if (state == S_IDLE && nonce_count == '0)
                            state <= S_DONE;
                        else
                            state <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (written == count_r) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            if (dsp_ok) begin
                core_start[dsp_sel]           <= 1'b1;
                core_nonce[32*dsp_sel +: 32]  <= base_r + 32'(next_idx);
                idx_r[dsp_sel]                <= next_idx;
                status[dsp_sel]               <= C_RUN;
                next_idx                      <= next_idx + 1'b1;
            end

            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_done[i] && status[i] == C_RUN) begin
                    status[i] <= C_PEND;
                    h0_r[i]   <= core_h0[32*i +: 32];
                end
            end

            // Write target is PENDING, so it never collides with dispatch/capture.
            if (wr_ok) begin
                mem_we         <= 1'b1;
                mem_addr       <= addr_r + 16'(idx_r[wr_sel]);
                mem_write_data <= h0_r[wr_sel];
                status[wr_sel] <= C_IDLE;
                written        <= written + 1'b1;
                rr_ptr         <= wr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler with a behavioural hash-core pool.
module tb_nonce_scheduler;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   nonce_base;
    logic [15:0]   nonce_count;
    logic [15:0]   output_addr;
    logic          busy;
    logic          done;
    logic [NC-1:0] core_start;
    logic [127:0]  core_nonce;
    logic [NC-1:0] core_done;
    logic [127:0]  core_h0;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_write_data;

    nonce_scheduler #(.NUM_CORES(NC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .nonce_base(nonce_base), .nonce_count(nonce_count),
        .output_addr(output_addr), .busy(busy), .done(done),
        .core_start(core_start), .core_nonce(core_nonce),
        .core_done(core_done), .core_h0(core_h0),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] disp_q[$];
    int          c0_cyc[$];
    int          we_cyc[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          cnt[NC];
    logic [31:0] seen[NC];
    int          starts[NC];
    int          lat[NC];
    int          job_starts = 0;
    int          n_writes = 0;
    int          last_we_cyc = 0;
    logic [31:0] h0_key = 32'h0;
    bit          strict = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core pool: done pulses lat[i] cycles after start, h0 = nonce ^ h0_key.
    initial begin
        core_done = '0;
        core_h0   = '0;
        for (int i = 0; i < NC; i++) begin
            cnt[i] = 0; seen[i] = 0; starts[i] = 0; lat[i] = 4;
        end
        forever begin
            @(negedge clk);
            core_done = '0;
            for (int i = 0; i < NC; i++) begin
                if (reset) begin
                    cnt[i] = 0;
                end else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            core_done[i]       = 1'b1;
                            core_h0[32*i +: 32] = seen[i] ^ h0_key;
                        end
                    end
                    if (core_start[i]) begin
                        seen[i] = core_nonce[32*i +: 32];
                        cnt[i]  = lat[i];
                        starts[i]++;
                        job_starts++;
                        disp_q.push_back(core_nonce[32*i +: 32]);
                        if (i == 0) c0_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && mem_we) begin
            int found;
            found = -1;
            n_writes++;
            last_we_cyc = cyc;
            we_cyc.push_back(cyc);
            foreach (sb[k])
                if (found < 0 && sb[k].addr == mem_addr) found = k;
            checks++;
            if (found < 0) begin
                failures++;
                $display("FAIL wr_addr actual=%0h required=<expected addr>",
                         mem_addr);
            end else begin
                if (strict) check("wr_order", found, 0);
                check("wr_data", mem_write_data, sb[found].data);
                sb.delete(found);
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    task automatic push_sweep(input logic [31:0] b, input int n,
                              input logic [15:0] oa);
        for (int k = 0; k < n; k++) begin
            logic [15:0] a;
            logic [31:0] nn;
            a  = oa + 16'(k);
            nn = b + 32'(k);
            push_exp(a, nn ^ h0_key);
        end
    endtask

    task automatic kick(input logic [31:0] b, input logic [15:0] n,
                        input logic [15:0] oa);
        @(negedge clk);
        n_writes = 0; job_starts = 0;
        disp_q.delete(); c0_cyc.delete(); we_cyc.delete();
        nonce_base = b; nonce_count = n; output_addr = oa;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n != 0) check("accept_busy_done", {busy, done}, 2'b10);
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", done, 1);
        if (done) begin
            check("busy_at_done", busy, 0);
            if (n > 0) check("done_lag", cyc - last_we_cyc, 1);
            check("n_writes", n_writes, n);
            check("n_starts", job_starts, n);
            check("sb_empty", sb.size(), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_core_nonce"}, core_nonce == '0, 1);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data"}, mem_write_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int pw;
        int ps;
        reset = 1'b1; start = 1'b0;
        nonce_base = '0; nonce_count = '0; output_addr = '0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;

        // Empty sweep goes straight to DONE.
        kick(32'h0, 16'd0, 16'h0010);
        check("cnt0_done", done, 1);
        repeat (3) @(negedge clk);
        wait_done(0);

        // Single nonce.
        lat = '{10, 10, 10, 10};
        h0_key = 32'h5 ^ 32'hDEADBEEF;
        strict = 1'b1;
        push_exp(16'h0100, 32'hDEADBEEF);
        ps = starts[0];
        kick(32'd5, 16'd1, 16'h0100);
        wait_done(1);
        check("t2_core0_started", starts[0] - ps, 1);
        if (disp_q.size() > 0) check("t2_nonce", disp_q[0], 32'd5);

        // Eight nonces, out-of-order completion.
        for (int i = 0; i < NC; i++) starts[i] = 0;
        lat = '{9, 7, 8, 6};
        h0_key = 32'h1234_5678;
        strict = 1'b0;
        push_sweep(32'h1000, 8, 16'h0200);
        kick(32'h1000, 16'd8, 16'h0200);
        wait_done(8);
        for (int i = 0; i < NC; i++) check("t3_starts_per_core", starts[i], 2);

        // Simultaneous completion: writes in core order, core0 reused.
        lat = '{13, 12, 11, 10};
        h0_key = 32'h0F0F_0F0F;
        strict = 1'b1;
        push_sweep(32'h2000, 5, 16'h0300);
        kick(32'h2000, 16'd5, 16'h0300);
        wait_done(5);
        if (we_cyc.size() >= 4)
            check("t4_consecutive", we_cyc[3] - we_cyc[0], 3);
        if (c0_cyc.size() >= 2 && we_cyc.size() >= 1)
            check("t4_core0_restart", c0_cyc[1] - we_cyc[0], 1);
        else
            check("t4_core0_restart_seen", c0_cyc.size(), 2);

        // Nonce and address wrap.
        lat = '{3, 3, 3, 3};
        h0_key = 32'hA5A5_0000;
        strict = 1'b0;
        push_sweep(32'hFFFF_FFFE, 4, 16'hFFFE);
        kick(32'hFFFF_FFFE, 16'd4, 16'hFFFE);
        wait_done(4);
        check("t5_ndisp", disp_q.size(), 4);
        if (disp_q.size() == 4) begin
            check("t5_n0", disp_q[0], 32'hFFFF_FFFE);
            check("t5_n1", disp_q[1], 32'hFFFF_FFFF);
            check("t5_n2", disp_q[2], 32'h0000_0000);
            check("t5_n3", disp_q[3], 32'h0000_0001);
        end

        // Abort mid-job, then a clean job.
        lat = '{9, 7, 8, 6};
        h0_key = 32'h3C3C_3C3C;
        push_sweep(32'h3000, 8, 16'h0400);
        kick(32'h3000, 16'd8, 16'h0400);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        pw = n_writes; ps = job_starts;
        repeat (4) @(negedge clk);
        check("abort_no_writes", n_writes - pw, 0);
        check("abort_no_starts", job_starts - ps, 0);
        check("abort_idle", {busy, done}, 2'b00);

        lat = '{4, 4, 4, 4};
        h0_key = 32'h0000_FFFF;
        strict = 1'b0;
        push_sweep(32'h50, 3, 16'h0040);
        kick(32'h50, 16'd3, 16'h0040);
        wait_done(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
